mudi_ctrl: RTL
==============

Name: mudi_ctrl

Overview:
Sequencer between E-stage and the iterative multiply/divide unit (mudi). Issues Start/MDOp/operands and owns the architectural HI/LO registers. Captures results when the unit completes, services MTHI/MTLO/MFHI/MFLO, and drives the D-stage stall for any HI/LO-touching instruction while an operation is in flight. Includes a watchdog and a reset bridge for the unit's synchronous active-high reset.

Parameters:
TIMEOUT, 16, max cycles in WAIT before abort; must exceed the longest unit latency (10)
CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  E-stage holds a HI/LO instruction this cycle
req_op  in  3  MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO (encodings in head.v)
req_a  in  32  rs value
req_b  in  32  rt value
d_is_md  in  1  D-stage instruction reads or writes HI/LO
stall  out  1  freeze PC/F/D, bubble into E
rd_data  out  32  MFHI/MFLO result for E-stage writeback mux
md_start  out  1  unit Start
md_op  out  2  unit MDOp (MULT=0, MULTU=1, DIV=2, DIVU=3)
md_a  out  32  unit A
md_b  out  32  unit B
md_rst  out  1  unit reset, active high
md_busy  in  1  unit Busy
md_hi  in  32  unit HI
md_lo  in  32  unit LO
err  out  1  sticky protocol/timeout flag

Behaviour:
- Reset (rst_n low, async): state=IDLE, hi_q=lo_q=0, wdog=0, err=0, md_rst=1. md_rst stays 1 through the first rising edge after rst_n rises, then drops (2-flop stretcher), so the unit sees at least one synchronous reset edge.
- md_start = req_valid & op∈{MULT,MULTU,DIV,DIVU} & state==IDLE & ~md_rst; combinational.
- md_a/md_b/md_op: req_a/req_b/req_op[1:0] passed through.
- States:
  - IDLE: start -> ISSUE.
  - ISSUE (1 cycle): covers the cycle before unit Busy rises; md_busy is ignored here; -> WAIT.
  - WAIT: while md_busy=1, wdog++. On md_busy=0: hi_q<=md_hi, lo_q<=md_lo, -> IDLE. On wdog==TIMEOUT: err<=1, hi_q/lo_q unchanged, -> IDLE.
- Latency: unit latency N busy cycles (MULT/MULTU N=5, DIV/DIVU N=10). Start in cycle 0; ISSUE edge 0; md_busy high cycles 1..N; capture edge at end of cycle N+1; hi_q valid from cycle N+2.
- stall = d_is_md & (md_start | state!=IDLE). Stalls for N+2 cycles when the following instruction is an MD op; unrelated instructions flow.
- MTHI/MTLO (req_valid, IDLE): hi_q or lo_q <= req_a at the edge. Same-cycle MFHI/MFLO cannot occur (single E slot).
- MFHI/MFLO: rd_data = hi_q or lo_q, combinational. In IDLE, rd_data=0 for other ops.
- Protocol violations: any req_valid while state!=IDLE is ignored and sets err. The stall rule prevents this in correct pipelines.
- Divide by zero: no special case; whatever the unit returns is captured.
- Reset mid-operation: state->IDLE, HI/LO cleared, md_rst pulses; the in-flight result is discarded.
- md_busy X/1 in IDLE is ignored.

Decomposition:
- head.v: req_op codes (`MDC_MULT..`MDC_MFLO, 3-bit), MDOp macros (reused as-is), state encodings (IDLE/ISSUE/WAIT, 2-bit).
- No sub-module required. The reset stretcher is inline (2 flops).

Test Plan:
- MULT a=0xFFFFFFFE, b=3, d_is_md=1 -> stall high 7 cycles; then MFHI returns 0xFFFFFFFF and MFLO returns 0xFFFFFFFA.
- DIVU a=100, b=7 -> stall 12 cycles; hi_q=2, lo_q=14; md_start high exactly 1 cycle.
- MTHI a=0x12345678 then MFHI next cycle -> rd_data=0x12345678; stall never asserted.
- MULT issued with d_is_md=0 on following instructions -> stall stays 0; later MFLO after completion reads the correct product.
- Force md_busy stuck 1 after DIV -> err=1 at WAIT cycle 16; state returns to IDLE; hi_q unchanged.
- rst_n low during WAIT of DIV -> outputs reset immediately; md_rst=1 until the first edge after release; subsequent MULT 6×7 gives lo_q=42.

Source files
------------

// File: rtl/mudi_ctrl_pkg.sv
// Shared encodings for the HI/LO sequencer: E-stage op codes, unit MDOp codes
// and the sequencer state type.
package mudi_ctrl_pkg;

    typedef enum logic [2:0] {
        MDC_MULT  = 3'd0,
        MDC_MULTU = 3'd1,
        MDC_DIV   = 3'd2,
        MDC_DIVU  = 3'd3,
        MDC_MTHI  = 3'd4,
        MDC_MTLO  = 3'd5,
        MDC_MFHI  = 3'd6,
        MDC_MFLO  = 3'd7
    } mdc_op_e;

    typedef enum logic [1:0] {
        MDOP_MULT  = 2'd0,
        MDOP_MULTU = 2'd1,
        MDOP_DIV   = 2'd2,
        MDOP_DIVU  = 2'd3
    } mdop_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } mdc_state_e;

    // Low four op codes go to the unit; their low two bits are the MDOp.
    function automatic logic is_unit_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mudi_ctrl.sv
// Sequencer between E-stage and the iterative mul/div unit: issues operations,
// owns HI/LO, stalls D-stage HI/LO users while busy, with watchdog and reset bridge.
module mudi_ctrl
    import mudi_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        d_is_md,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_rst,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        err
);

    mdc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              err_q, err_d;
    logic [1:0]        rst_sync_q;

    // Unit reset asserts with rst_n and is held across the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign md_rst   = rst_sync_q[1];
    assign md_start = req_valid & is_unit_op(req_op) & (state_q == ST_IDLE) & ~md_rst;
    assign md_op    = req_op[1:0];
    assign md_a     = req_a;
    assign md_b     = req_b;
    assign stall    = d_is_md & (md_start | (state_q != ST_IDLE));
    assign err      = err_q;

    always_comb begin
        rd_data = '0;
        if (req_valid) begin
            if (req_op == MDC_MFHI) begin
                rd_data = hi_q;
            end else if (req_op == MDC_MFLO) begin
                rd_data = lo_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (md_start) begin
                    state_d = ST_ISSUE;
                end else if (req_valid && req_op == MDC_MTHI) begin
                    hi_d = req_a;
                end else if (req_valid && req_op == MDC_MTLO) begin
                    lo_d = req_a;
                end
            end
            ST_ISSUE: begin
                // Busy has not risen yet in this cycle, so it is not looked at.
                wdog_d  = '0;
                state_d = ST_WAIT;
                if (req_valid) begin
                    err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (req_valid) begin
                    err_d = 1'b1;
                end
                if (!md_busy) begin
                    hi_d    = md_hi;
                    lo_d    = md_lo;
                    state_d = ST_IDLE;
                end else if (wdog_q == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wdog_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

endmodule
